axi_stream_packer: RTL and testbench

// - Packs a narrow valid/ready pixel stream into wide words for the frame-buffer write path.
// - Sits directly upstream of the register slice in front of the DDR write master.
// - Collects RATIO input beats per output word; in_last flushes a partial word early.

---
 rtl/axi_stream_packer.sv | 66 ++++++
 tb/tb_axi_stream_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_packer.sv
// axi_stream_packer: packs RATIO narrow beats into one wide word; optional lane mask under AXI_STREAM_PACKER_KEEP_EN
module axi_stream_packer #(
  parameter int IN_WIDTH = 16,
  parameter int RATIO = 8,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef AXI_STREAM_PACKER_KEEP_EN
  ,
  output logic [RATIO-1:0]     out_keep
`endif
);
  localparam int CW = $clog2(RATIO);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic accept, done;
  logic [OUT_WIDTH-1:0] data_nxt;
  assign out_valid = state == HOLD;
  assign in_ready = ~out_valid | out_ready;
  assign accept = in_valid & in_ready;
  assign done = accept & (in_last | cnt == CW'(RATIO - 1));
  // assembly register doubles as the output word and restarts from zero on each word's first beat
  always_comb begin
    data_nxt = cnt == '0 ? '0 : out_data;
    data_nxt[cnt*IN_WIDTH +: IN_WIDTH] = in_data;
  end
  // FILL/HOLD control, lane counter and registered word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= FILL;
      cnt      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= done ? HOLD : out_ready ? FILL : state;
      if (accept) begin
        out_data <= data_nxt;
        cnt      <= done ? '0 : cnt + 1'b1;
      end
      if (done) out_last <= in_last;
    end
  end
`ifdef AXI_STREAM_PACKER_KEEP_EN
  logic [RATIO-1:0] keep_nxt;
  // lane mask grows with each accepted beat and restarts with each word
  always_comb begin
    keep_nxt = cnt == '0 ? '0 : out_keep;
    keep_nxt[cnt] = 1'b1;
  end
  // registered lane mask travels with the word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_keep <= '0;
    else if (accept) out_keep <= keep_nxt;
  end
`endif
endmodule

// File: tb/tb_axi_stream_packer.sv
// tb_axi_stream_packer: directed and randomised checks of the stream packer with a word scoreboard
module tb_axi_stream_packer;
  localparam int IW = 16;
  localparam int R = 8;
  localparam int OW = IW * R;
  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
    logic [R-1:0]  k;
  } word_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [OW-1:0] out_data;
  logic out_last, out_valid, out_ready;
  logic dir_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rand_mode = 1'b0;
`ifdef AXI_STREAM_PACKER_KEEP_EN
  logic [R-1:0] out_keep;
`endif
  word_t q[$];
  logic [OW-1:0] m_word = '0;
  logic [R-1:0] m_keep = '0;
  logic [OW-1:0] w;
  int m_cnt = 0;
  int checks = 0;
  int fails = 0;
  int last_wait = 0;
  int stalls = 0;

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  axi_stream_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_data(in_data),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef AXI_STREAM_PACKER_KEEP_EN
    ,
    .out_keep(out_keep)
`endif
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (rstn && out_valid && out_ready) begin
      chk("word_pending", OW'(q.size() > 0), OW'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", OW'(out_last), OW'(e.l));
`ifdef AXI_STREAM_PACKER_KEEP_EN
        chk("out_keep", OW'(out_keep), OW'(e.k));
`endif
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    last_wait = 0;
    @(negedge clk);
    while (!in_ready && last_wait < 200) begin
      last_wait++;
      @(negedge clk);
    end
    chk("accept_bound", OW'(last_wait < 200), OW'(1));
    stalls += last_wait;
    @(posedge clk);
    #1;
    m_word[m_cnt*IW +: IW] = d;
    m_keep[m_cnt] = 1'b1;
    m_cnt++;
    if (m_cnt == R || l) begin
      q.push_back(word_t'{d: m_word, l: l, k: m_keep});
      m_word = '0;
      m_keep = '0;
      m_cnt = 0;
    end
  endtask

  task automatic reset_mid();
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_data", out_data, OW'(0));
    chk("rst_out_last", OW'(out_last), OW'(0));
    q.delete();
    m_word = '0;
    m_keep = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    dir_ready = 1'b1;
    rand_mode = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", OW'(q.size()), OW'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", OW'(out_valid), OW'(0));
    chk("init_out_data", out_data, OW'(0));
    chk("init_out_last", OW'(out_last), OW'(0));
    chk("init_in_ready", OW'(in_ready), OW'(1));
    rstn = 1'b1;
    dir_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i), 1'b0);
    reset_mid();
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 1'b0);
      if (i == 7) chk("t2_not_yet", OW'(out_valid), OW'(0));
    end
    in_valid = 1'b0;
    chk("t2_latency", OW'(out_valid), OW'(1));
    @(posedge clk);
    #1;
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dir_ready = 1'b0;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      send(16'h0010 + 16'(i), 1'b0);
      w[i*IW +: IW] = 16'h0010 + 16'(i);
    end
    in_data = 16'h0020;
    in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_in_ready", OW'(in_ready), OW'(0));
      chk("t4_hold_data", out_data, w);
    end
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    send(16'h0020, 1'b0);
    chk("t4_first_accept", OW'(last_wait), OW'(0));
    for (int i = 1; i < 8; i++) send(16'h0020 + 16'(i), i == 7);
    in_valid = 1'b0;
    stalls = 0;
    for (int i = 0; i < 64; i++) send(16'h1000 + 16'(i), i == 63);
    in_valid = 1'b0;
    chk("t5_no_stall", OW'(stalls), OW'(0));
    drain();
    rand_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(16'h2000 + 16'(i), i == 12);
    end
    in_valid = 1'b0;
    drain();
    dir_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h3000 + 16'(i), 1'b0);
    in_valid = 1'b0;
    chk("hold_valid", OW'(out_valid), OW'(1));
    reset_mid();
    dir_ready = 1'b1;
    send(16'h4444, 1'b1);
    in_valid = 1'b0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
